// File: rtl/ip_encode.sv
// ---------------------------------------------------------------------------
// ip_encode
// Byte-serial IPv4 header generator and payload framer (transmit path).
// On an accepted start the addressing/length fields are latched, the header
// checksum is accumulated one 16-bit word per cycle, then a 20-byte IPv4
// header (IHL=5, no options) is emitted big-endian, followed by payload_len
// payload bytes passed straight through from the upstream source.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               packet request, sampled only in IDLE
//   sa, da              source / destination address (latched on start)
//   protocol            IP protocol number (latched on start)
//   payload_len         payload byte count (latched on start, max 65515)
//   pl_din/pl_valid     upstream payload byte stream
//   pl_ready            payload byte accepted this cycle
//   dout/dout_valid     output byte stream towards the Ethernet TX framer
//   dout_ready          downstream accepts byte
//   busy                high in any state other than IDLE
//   done                one-cycle pulse after the final byte transfers
//   err                 one-cycle pulse when start is rejected (oversize)
// ---------------------------------------------------------------------------
module ip_encode #(
  parameter logic [7:0] TTL = 8'd64,
  parameter logic       DF  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sa,
  input  logic [31:0] da,
  input  logic [7:0]  protocol,
  input  logic [15:0] payload_len,
  input  logic [7:0]  pl_din,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FOLD,
    S_HEADER,
    S_PAYLOAD,
    S_DONE
  } state_t;

  // Largest payload that keeps total_len = payload_len + 20 within 16 bits.
  localparam logic [15:0] MAX_PL_LEN = 16'd65515;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_sa;
  logic [31:0] r_da;
  logic [7:0]  r_proto;
  logic [15:0] r_len;
  logic [15:0] r_total;
  logic [15:0] r_ident;
  logic [15:0] r_acc;
  logic [15:0] r_csum;
  logic [3:0]  r_widx;
  logic [4:0]  r_bidx;
  logic [15:0] r_pcnt;
  logic [7:0]  r_dout;
  logic        r_dout_valid;
  logic        r_err;

  logic        w_accept;
  logic        w_reject;
  logic        w_hdr_xfer;
  logic        w_pl_xfer;
  logic [15:0] w_pcnt_next;
  logic [4:0]  w_load_idx;
  logic [3:0]  w_word_idx;
  logic [15:0] w_csum_field;
  logic [15:0] w_word;
  logic [7:0]  w_hdr_byte;
  logic [16:0] w_sum;

  assign w_accept    = (r_state == S_IDLE) && start && (payload_len <= MAX_PL_LEN);
  assign w_reject    = (r_state == S_IDLE) && start && (payload_len >  MAX_PL_LEN);
  assign w_hdr_xfer  = (r_state == S_HEADER) && r_dout_valid && dout_ready;
  assign w_pl_xfer   = (r_state == S_PAYLOAD) && pl_valid && dout_ready;
  assign w_pcnt_next = r_pcnt + 16'd1;

  // Byte to load into the output register: the current index while the
  // register is empty, otherwise the one after the byte now transferring.
  assign w_load_idx  = r_dout_valid ? (r_bidx + 5'd1) : r_bidx;

  // One header-word mux shared by the checksum pass and the byte emitter;
  // the checksum field reads as zero while it is still being computed.
  assign w_word_idx   = (r_state == S_CALC) ? r_widx : w_load_idx[4:1];
  assign w_csum_field = (r_state == S_CALC) ? 16'h0000 : r_csum;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_word = 16'h0000;
    case (w_word_idx)
      4'd0:    w_word = {4'h4, 4'h5, 8'h00};
      4'd1:    w_word = r_total;
      4'd2:    w_word = r_ident;
      4'd3:    w_word = {1'b0, DF, 14'b0};
      4'd4:    w_word = {TTL, r_proto};
      4'd5:    w_word = w_csum_field;
      4'd6:    w_word = r_sa[31:16];
      4'd7:    w_word = r_sa[15:0];
      4'd8:    w_word = r_da[31:16];
      4'd9:    w_word = r_da[15:0];
      default: w_word = 16'h0000;
    endcase
  end

  // Big-endian: even byte index is the high half of the word.
  assign w_hdr_byte = w_load_idx[0] ? w_word[7:0] : w_word[15:8];
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_word};

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // -------------------------------------------------------------------------
  // FSM next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    err          = r_err;
    pl_ready     = 1'b0;
    dout         = r_dout;
    dout_valid   = r_dout_valid;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_CALC;
      S_CALC:    if (r_widx == 4'd9) w_next_state = S_FOLD;
      S_FOLD:    w_next_state = S_HEADER;
      S_HEADER: begin
        if (w_hdr_xfer && (r_bidx == 5'd19))
          w_next_state = (r_len != 16'd0) ? S_PAYLOAD : S_DONE;
      end
      S_PAYLOAD: begin
        // Payload bypasses the output register entirely.
        dout       = pl_din;
        dout_valid = pl_valid;
        pl_ready   = dout_ready;
        if (w_pl_xfer && (w_pcnt_next == r_len)) w_next_state = S_DONE;
      end
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa         <= '0;
      r_da         <= '0;
      r_proto      <= '0;
      r_len        <= '0;
      r_total      <= '0;
      r_ident      <= '0;
      r_acc        <= '0;
      r_csum       <= '0;
      r_widx       <= '0;
      r_bidx       <= '0;
      r_pcnt       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sa    <= sa;
            r_da    <= da;
            r_proto <= protocol;
            r_len   <= payload_len;
            r_total <= payload_len + 16'd20;
            r_acc   <= '0;
            r_widx  <= '0;
          end
          if (w_reject) r_err <= 1'b1;
        end
        S_CALC: begin
          // Ones-complement add: the carry out is folded back every cycle,
          // and the folded value can never carry again (max 0xFFFE + 1).
          r_acc  <= w_sum[15:0] + {15'd0, w_sum[16]};
          r_widx <= r_widx + 4'd1;
        end
        S_FOLD: begin
          // Carry is already folded in CALC, so only the complement remains.
          // A result of 0x0000 is sent as-is.
          r_csum       <= ~r_acc;
          r_bidx       <= '0;
          r_pcnt       <= '0;
          r_dout_valid <= 1'b0;
        end
        S_HEADER: begin
          if (!r_dout_valid) begin
            r_dout       <= w_hdr_byte;
            r_dout_valid <= 1'b1;
          end else if (dout_ready) begin
            if (r_bidx == 5'd19) begin
              r_dout       <= '0;
              r_dout_valid <= 1'b0;
            end else begin
              r_bidx <= r_bidx + 5'd1;
              r_dout <= w_hdr_byte;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_pl_xfer) r_pcnt <= w_pcnt_next;
        end
        S_DONE: begin
          r_ident <= r_ident + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
